// File: rtl/iddr_word_align_if.sv
// iddr_word_align port bundle: IDDR-side controls/data in,
// bitslip request, lock status and forwarded data out.
interface iddr_word_align_if #(
    parameter int DATA_W = 8
);
    logic              i_align_en;
    logic              i_iddr_ready;
    logic [DATA_W-1:0] i_rx_data;
    logic              i_rx_valid;
    logic              o_alignwd;
    logic              o_locked;
    logic              o_align_fail;
    logic [3:0]        o_slip_cnt;
    logic [DATA_W-1:0] o_rx_data;
    logic              o_rx_valid;

    modport slave (
        input  i_align_en,
        input  i_iddr_ready,
        input  i_rx_data,
        input  i_rx_valid,
        output o_alignwd,
        output o_locked,
        output o_align_fail,
        output o_slip_cnt,
        output o_rx_data,
        output o_rx_valid
    );

    modport master (
        output i_align_en,
        output i_iddr_ready,
        output i_rx_data,
        output i_rx_valid,
        input  o_alignwd,
        input  o_locked,
        input  o_align_fail,
        input  o_slip_cnt,
        input  o_rx_data,
        input  o_rx_valid
    );
endinterface

// File: rtl/iddr_word_align.sv
// IDDR word aligner: bitslips until TRAIN_PAT repeats, then locks.
// Define IDDR_ALIGN_RETRY_EN to auto-retry after FAIL.
module iddr_word_align #(
    parameter int         DATA_W     = 8,
    parameter logic [7:0] TRAIN_PAT  = 8'h5C,
    parameter int         MATCH_NUM  = 16,
    parameter int         SETTLE_CYC = 8,
    parameter int         RETRY_CYC  = 1024
) (
    input logic              i_clk,
    input logic              i_rst_n,
    iddr_word_align_if.slave bus
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WAIT_RDY = 3'd1;
    localparam logic [2:0] CHECK    = 3'd2;
    localparam logic [2:0] SLIP     = 3'd3;
    localparam logic [2:0] SETTLE   = 3'd4;
    localparam logic [2:0] LOCKED   = 3'd5;
    localparam logic [2:0] FAIL     = 3'd6;

    localparam logic [DATA_W-1:0] PAT  = TRAIN_PAT[DATA_W-1:0];
    localparam logic [7:0] MATCH_LAST  = 8'(MATCH_NUM - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [3:0] SLIP_MAX    = 4'(DATA_W - 1);

    if (!(DATA_W == 4 || DATA_W == 8) ||
        MATCH_NUM < 1 || MATCH_NUM > 255 ||
        SETTLE_CYC < 1 || SETTLE_CYC > 255 ||
        RETRY_CYC < 1 || RETRY_CYC > 65535) begin : g_param_err
        $error("iddr_word_align: parameter out of range");
    end

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [7:0] match_cnt;
    logic [7:0] settle_cnt;
    logic [3:0] slip_cnt;
    logic       word_ok;
    logic       rdy_lost;
    logic       match_done;
    logic       settle_done;
    logic       slip_last;
    logic       retry_done;

    assign word_ok     = (bus.i_rx_data == PAT);
    assign match_done  = (match_cnt == MATCH_LAST);
    assign settle_done = (settle_cnt == SETTLE_LAST);
    assign slip_last   = (slip_cnt == SLIP_MAX);
    assign rdy_lost    = !bus.i_iddr_ready &&
                         (state == CHECK || state == SLIP ||
                          state == SETTLE || state == LOCKED);

`ifdef IDDR_ALIGN_RETRY_EN
    localparam logic [15:0] RETRY_LAST = 16'(RETRY_CYC - 1);

    logic [15:0] retry_cnt;

    assign retry_done = (retry_cnt == RETRY_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            retry_cnt <= '0;
        end else if (!bus.i_align_en || state != FAIL) begin
            retry_cnt <= '0;
        end else if (!retry_done) begin
            retry_cnt <= retry_cnt + 16'd1;
        end
    end
`else
    // FAIL is sticky: only i_align_en or reset leave it
    assign retry_done = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        if (!bus.i_align_en) begin
            state_nxt = IDLE;
        end else if (rdy_lost) begin
            state_nxt = WAIT_RDY;
        end else begin
            case (state)
                IDLE: state_nxt = WAIT_RDY;
                WAIT_RDY: begin
                    if (bus.i_iddr_ready) state_nxt = CHECK;
                end
                CHECK: begin
                    if (bus.i_rx_valid) begin
                        if (word_ok) begin
                            if (match_done) state_nxt = LOCKED;
                        end else if (slip_last) begin
                            state_nxt = FAIL;
                        end else begin
                            state_nxt = SLIP;
                        end
                    end
                end
                SLIP: state_nxt = SETTLE;
                SETTLE: begin
                    if (settle_done) state_nxt = CHECK;
                end
                LOCKED: state_nxt = LOCKED;
                FAIL: begin
                    if (retry_done) state_nxt = WAIT_RDY;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            match_cnt  <= '0;
            settle_cnt <= '0;
            slip_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (!bus.i_align_en) begin
                match_cnt  <= '0;
                settle_cnt <= '0;
                slip_cnt   <= '0;
            end else if (rdy_lost) begin
                match_cnt  <= '0;
                settle_cnt <= '0;
                slip_cnt   <= '0;
            end else begin
                case (state)
                    WAIT_RDY: match_cnt <= '0;
                    CHECK: begin
                        // a mismatch throws away any partial run
                        if (bus.i_rx_valid) begin
                            if (!word_ok) begin
                                match_cnt <= '0;
                            end else if (!match_done) begin
                                match_cnt <= match_cnt + 8'd1;
                            end
                        end
                    end
                    SLIP: begin
                        if (!slip_last) slip_cnt <= slip_cnt + 4'd1;
                        settle_cnt <= '0;
                    end
                    SETTLE: begin
                        if (!settle_done) settle_cnt <= settle_cnt + 8'd1;
                    end
                    FAIL: begin
                        if (retry_done) begin
                            slip_cnt  <= '0;
                            match_cnt <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // status flags track the state being entered so they line up with it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_alignwd    <= 1'b0;
            bus.o_locked     <= 1'b0;
            bus.o_align_fail <= 1'b0;
            bus.o_rx_data    <= '0;
            bus.o_rx_valid   <= 1'b0;
        end else begin
            bus.o_alignwd    <= (state_nxt == SLIP);
            bus.o_locked     <= (state_nxt == LOCKED);
            bus.o_align_fail <= (state_nxt == FAIL);
            bus.o_rx_data    <= bus.i_rx_data;
            bus.o_rx_valid   <= bus.i_rx_valid &&
                                (state == LOCKED) &&
                                (state_nxt == LOCKED);
        end
    end

    assign bus.o_slip_cnt = slip_cnt;

endmodule

// File: tb/tb_iddr_word_align.sv
// Directed bench for iddr_word_align with a rotating-IDDR data model.
// Build with +define+IDDR_ALIGN_RETRY_EN to exercise the retry path.
module tb_iddr_word_align;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    iddr_word_align_if #(.DATA_W(8)) bus();

    iddr_word_align #(
        .DATA_W    (8),
        .TRAIN_PAT (8'h5C),
        .MATCH_NUM (16),
        .SETTLE_CYC(8),
        .RETRY_CYC (1024)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    int   n_chk     = 0;
    int   n_pass    = 0;
    int   cyc       = 0;
    int   pulses    = 0;
    int   last_rise = -1000;
    int   min_gap   = 1000;
    int   wide      = 0;
    int   rot       = 0;
    int   n         = 0;
    logic prev_wd   = 1'b0;
    logic zero_mode = 1'b0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
        logic [15:0] t;
        t = {x, x} << (k % 8);
        return t[15:8];
    endfunction

    task automatic drive_word();
        bus.i_rx_data = zero_mode ? 8'h00 : rotl(8'h5C, rot);
    endtask

    // one clock; the model IDDR rotates its word on each alignwd pulse
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.o_alignwd && !prev_wd) begin
            pulses++;
            if (cyc - last_rise < min_gap) min_gap = cyc - last_rise;
            last_rise = cyc;
            rot++;
        end
        if (bus.o_alignwd && prev_wd) wide++;
        prev_wd = bus.o_alignwd;
        drive_word();
    endtask

    task automatic clear_stats();
        pulses    = 0;
        last_rise = -1000;
        min_gap   = 1000;
        wide      = 0;
    endtask

    task automatic run_until(input int which, input int budget,
                             output int cnt);
        cnt = 0;
        while (cnt < budget &&
               !(which == 0 ? bus.o_locked :
                 which == 1 ? bus.o_align_fail : bus.o_alignwd)) begin
            tick();
            cnt++;
        end
    endtask

    task automatic restart(input logic zm, input int r);
        bus.i_align_en = 1'b0;
        tick();
        clear_stats();
        zero_mode = zm;
        rot       = r;
        drive_word();
        bus.i_align_en = 1'b1;
    endtask

    initial begin
        bus.i_align_en   = 1'b0;
        bus.i_iddr_ready = 1'b0;
        bus.i_rx_valid   = 1'b0;
        bus.i_rx_data    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_alignwd", bus.o_alignwd, 0);
        check("rst_locked", bus.o_locked, 0);
        check("rst_fail", bus.o_align_fail, 0);
        check("rst_slip", bus.o_slip_cnt, 0);
        check("rst_rxdata", bus.o_rx_data, 0);
        check("rst_rxvalid", bus.o_rx_valid, 0);
        rst_n = 1'b1;

        // aligned stream
        clear_stats();
        zero_mode = 1'b0;
        rot       = 0;
        drive_word();
        bus.i_align_en   = 1'b1;
        bus.i_iddr_ready = 1'b1;
        bus.i_rx_valid   = 1'b1;
        run_until(0, 100, n);
        check("aligned_lock_lat", n, 18);
        check("aligned_pulses", pulses, 0);
        check("aligned_slip", bus.o_slip_cnt, 0);
        check("rxvalid_at_lock", bus.o_rx_valid, 0);
        tick();
        check("rxvalid_after", bus.o_rx_valid, 1);
        check("rxdata_after", bus.o_rx_data, 8'h5C);

        // ready drop while locked
        bus.i_iddr_ready = 1'b0;
        tick();
        check("drop_locked", bus.o_locked, 0);
        check("drop_rxvalid", bus.o_rx_valid, 0);
        bus.i_iddr_ready = 1'b1;
        run_until(0, 100, n);
        check("relock_lat", n, 17);

        // misaligned by 3
        restart(1'b0, 5);
        run_until(0, 400, n);
        check("mis3_locked", bus.o_locked, 1);
        check("mis3_pulses", pulses, 3);
        check("mis3_slip", bus.o_slip_cnt, 3);
        check("mis3_gap", min_gap, 10);
        check("mis3_width", wide, 0);

        // never matching
        restart(1'b1, 0);
        run_until(1, 400, n);
        check("nm_fail", bus.o_align_fail, 1);
        check("nm_pulses", pulses, 7);
        check("nm_slip", bus.o_slip_cnt, 7);
        check("nm_locked", bus.o_locked, 0);
`ifdef IDDR_ALIGN_RETRY_EN
        repeat (1023) tick();
        check("retry_hold_fail", bus.o_align_fail, 1);
        check("retry_hold_pulses", pulses, 7);
        tick();
        check("retry_fail_clr", bus.o_align_fail, 0);
        check("retry_slip_clr", bus.o_slip_cnt, 0);
`else
        repeat (50) tick();
        check("sticky_fail", bus.o_align_fail, 1);
        check("sticky_pulses", pulses, 7);
        check("sticky_slip", bus.o_slip_cnt, 7);
`endif

        // disable mid-SETTLE, then restart aligned
        restart(1'b1, 0);
        run_until(2, 50, n);
        repeat (3) tick();
        check("settle_slip_pre", bus.o_slip_cnt, 1);
        bus.i_align_en = 1'b0;
        tick();
        check("dis_alignwd", bus.o_alignwd, 0);
        check("dis_locked", bus.o_locked, 0);
        check("dis_fail", bus.o_align_fail, 0);
        check("dis_slip", bus.o_slip_cnt, 0);
        check("dis_rxvalid", bus.o_rx_valid, 0);
        clear_stats();
        zero_mode = 1'b0;
        rot       = 0;
        drive_word();
        bus.i_align_en = 1'b1;
        run_until(0, 100, n);
        check("reen_lock_lat", n, 18);
        check("reen_pulses", pulses, 0);

        // async reset during SLIP
        restart(1'b0, 5);
        run_until(2, 50, n);
        check("slip_seen", bus.o_alignwd, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_alignwd", bus.o_alignwd, 0);
        check("arst_slip", bus.o_slip_cnt, 0);
        check("arst_locked", bus.o_locked, 0);
        check("arst_fail", bus.o_align_fail, 0);
        check("arst_rxdata", bus.o_rx_data, 0);
        check("arst_rxvalid", bus.o_rx_valid, 0);
        #10;
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/iddr_word_align.md
# iddr_word_align

Word-alignment controller sitting directly downstream of the IDDR gearing and its init sequencer in the mpt2042 receive path. Once the IDDR reports ready, it checks the deserialized parallel words against a fixed training pattern. While the pattern is not seen, it issues single-cycle alignwd (bitslip) pulses to the IDDR, waiting a settle period after each pulse. When the pattern holds for a run of consecutive words it declares lock and forwards data downstream; if every rotation fails it reports failure.

## Interface
- DATA_W, 8 — parallel word width from IDDR; legal values 4 or 8.
- TRAIN_PAT, 8'h5C — training word; must be rotation-unique over DATA_W bits.
- MATCH_NUM, 16 — consecutive matching valid words required for lock (1..255).
- SETTLE_CYC, 8 — idle cycles after each alignwd pulse before comparing resumes (1..255).
- RETRY_CYC, 1024 — FAIL hold time before auto-retry (1..65535); used only with the retry macro.

- i_clk  in  1  — receive-domain clock.
- i_rst_n  in  1  — reset i_rst_n, asynchronous, active-low; clock i_clk.
- i_align_en  in  1  — level enable; low forces IDLE synchronously.
- i_iddr_ready  in  1  — IDDR ready from gearing/init logic.
- i_rx_data  in  DATA_W  — parallel word from IDDR.
- i_rx_valid  in  1  — i_rx_data qualifier.
- o_alignwd  out  1  — bitslip pulse to IDDR, one cycle wide.
- o_locked  out  1  — alignment achieved.
- o_align_fail  out  1  — all DATA_W rotations exhausted.
- o_slip_cnt  out  4  — alignwd pulses issued since the last (re)start.
- o_rx_data  out  DATA_W  — registered i_rx_data.
- o_rx_valid  out  1  — registered i_rx_valid gated by lock.

## Operation
- FSM states: IDLE, WAIT_RDY, CHECK, SLIP, SETTLE, LOCKED, FAIL.
- Transition priority:
  - i_align_en=0 → IDLE from any state; clears all counters.
  - i_iddr_ready=0 in CHECK, SLIP, SETTLE or LOCKED → WAIT_RDY; clears match_cnt and slip_cnt.
  - State-specific rules below.
- IDLE: i_align_en=1 → WAIT_RDY.
- WAIT_RDY: i_iddr_ready=1 → CHECK; match_cnt=0.
- CHECK: words are evaluated only when i_rx_valid=1; invalid cycles hold state.
  - i_rx_data==TRAIN_PAT[DATA_W-1:0]: match_cnt+1. When it reaches MATCH_NUM → LOCKED.
  - Mismatch with slip_cnt<DATA_W-1 → SLIP; match_cnt=0. A partial run is discarded.
  - Mismatch with slip_cnt==DATA_W-1 → FAIL.
- SLIP: lasts one cycle; o_alignwd=1; slip_cnt+1 → SETTLE.
- SETTLE: counts SETTLE_CYC cycles, ignoring data, then → CHECK.
- LOCKED: o_locked=1. Data is payload and is not compared. Exits only via i_iddr_ready or i_align_en.
- FAIL: o_align_fail=1. No further alignwd pulses.
- Counter widths: match_cnt 8 bits; settle_cnt 8 bits; retry_cnt 16 bits; slip_cnt 4 bits. slip_cnt never exceeds DATA_W-1; no counter wraps.

## Timing
- Reset values: o_alignwd=0, o_locked=0, o_align_fail=0, o_slip_cnt=0, o_rx_data=0, o_rx_valid=0; state=IDLE.
- All outputs are registered.
  - o_alignwd is high exactly during the SLIP cycle.
  - o_locked rises in the cycle after the MATCH_NUM-th matching valid word.
- Minimum spacing between alignwd rising edges is SETTLE_CYC+2 cycles.
- o_rx_data follows i_rx_data with 1-cycle latency, unconditionally.
- o_rx_valid is 1-cycle-latency i_rx_valid, ANDed with being in LOCKED on that input cycle. The first forwarded word is the first valid word after lock.
- Loss of i_iddr_ready or i_align_en clears o_locked and o_rx_valid on the next edge.
- Asynchronous reset mid-operation returns all outputs to reset values immediately. An alignwd pulse in flight is truncated.

## Configuration
- IDDR_ALIGN_RETRY_EN defined:
  - FAIL counts RETRY_CYC cycles.
  - It then clears slip_cnt, match_cnt and o_align_fail, and enters WAIT_RDY.
- IDDR_ALIGN_RETRY_EN undefined:
  - FAIL is sticky until i_align_en=0 or reset.
  - The retry counter is not synthesized.

## Test plan
- Aligned stream: i_align_en=1, i_iddr_ready=1, continuous valid 8'h5C → o_locked=1 one cycle after the 16th word; zero alignwd pulses; o_slip_cnt=0.
- Misaligned by 3: the bench model rotates its output by one bit on each alignwd → exactly 3 single-cycle pulses, spaced ≥10 cycles; then lock with o_slip_cnt=3.
- Never matching (8'h00): 7 pulses, then o_align_fail=1 with no 8th pulse.
  - Macro undefined: fail holds.
  - Macro defined: after 1024 cycles fail clears and o_slip_cnt=0.
- While locked, drop i_iddr_ready for 1 cycle → o_locked=0 and o_rx_valid=0 on the next edge. Re-raise with aligned data → relock after 16 words.
- Deassert i_align_en mid-SETTLE → IDLE and all outputs at reset values next cycle. Re-enable → full sequence restarts from slip_cnt=0.
- Assert i_rst_n=0 asynchronously during SLIP → o_alignwd=0 immediately, all outputs at reset values.
